// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART receive path.
package uart_pkg;

    // Default oversampling: 100 MHz system clock, 9600 baud line.
    localparam int CLKS_PER_BIT_DEFAULT = 10416;

    // Frame geometry: 1 start + 8 data (LSB first) + 1 stop, no parity.
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Receiver states; the encoding is also driven out on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// It resets to 1 so that an idle-high serial line does not look like a
// start bit while reset is being released.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: a plain two-stage shift of the input.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, forced to the idle level by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 8N1 frames, mid-bit sampling, one-byte holding register.
//
// Consumer handshake: VALID is high while DATA holds a byte that has not
// been acknowledged. The consumer raises ACK for a cycle in which VALID is
// high; VALID drops on the following cycle. ACK while VALID is low has no
// effect. A byte that completes while VALID is still high replaces DATA and
// pulses OVERRUN, unless ACK is high in that very cycle, in which case the
// old byte counts as consumed and no OVERRUN is raised.
//
// STATE_DBG exposes the FSM state register for observation only.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       UART_RX,
    input  logic       ACK,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY,
    output logic [2:0] STATE_DBG
);

    // Bit-period counter is just wide enough to reach CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Terminal counts: half a bit to reach mid start bit, a full bit after.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic                   rx_s;

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    // Per-cycle events raised by the FSM for the output register logic.
    logic                   byte_done;
    logic                   stop_bad;

    sync_2ff u_sync_rx (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (UART_RX),
        .q     (rx_s)
    );

    // FSM next state: start detect, mid-bit sampling, stop check, break wait.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                // Re-check the line at mid start bit; a high level means the
                // falling edge was a glitch and the frame is dropped silently.
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_HIGH: begin
                // Hold off until the line returns high so a long break
                // produces a single framing error, not a stream of them.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // Holding register, VALID handshake and the two error pulses.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = stop_bad;
        overrun_d   = byte_done && valid_q && !ACK;

        if (byte_done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (ACK && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = frame_err_q;
    assign OVERRUN   = overrun_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl with a cycle-level behavioural model of the receiver.
module tb_uart_rx_ctrl;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    // ---------------- clock / reset / DUT ----------------
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       UART_RX = 1'b1;
    logic       ACK = 1'b0;
    logic [7:0] DATA;
    logic       VALID, FRAME_ERR, OVERRUN, BUSY;
    logic [2:0] state_dbg;

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .UART_RX   (UART_RX),
        .ACK       (ACK),
        .DATA      (DATA),
        .VALID     (VALID),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN),
        .BUSY      (BUSY),
        .STATE_DBG (state_dbg)
    );

    int cyc = 0;
    always @(posedge CLK) cyc++;

    // ---------------- scoreboard bookkeeping ----------------
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time is counted in clock edges since the synchronized falling edge was
    // seen: mid start bit at HALF, data bit k at HALF+(k+1)*CPB, stop at
    // HALF+9*CPB.
    logic       m_s1 = 1'b1, m_s2 = 1'b1;
    bit         m_active = 0, m_wait = 0;
    int         m_t = 0;
    logic [7:0] m_shift = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_active = 0; m_wait = 0; m_t = 0;
            m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        end else begin
            logic rx;
            bit   done;
            bit   ferr;
            int   k;
            rx   = m_s2;
            m_s2 = m_s1;
            m_s1 = UART_RX;
            done = 0;
            ferr = 0;
            if (m_wait) begin
                if (rx) m_wait = 0;
            end else if (!m_active) begin
                if (!rx) begin
                    m_active = 1;
                    m_t = 0;
                end
            end else begin
                m_t++;
                if (m_t == HALF) begin
                    if (rx) m_active = 0;
                end else if (m_t > HALF && ((m_t - HALF) % CPB) == 0) begin
                    k = (m_t - HALF) / CPB;
                    if (k <= 8) begin
                        m_shift[k-1] = rx;
                    end else begin
                        m_active = 0;
                        if (rx) done = 1;
                        else begin
                            ferr = 1;
                            m_wait = 1;
                        end
                    end
                end
            end
            m_ovr  = done && m_valid && !ACK;
            m_ferr = ferr;
            if (done) begin
                m_valid = 1'b1;
                m_data  = m_shift;
                if (exp_q.size() == 0) check("sb_unexpected_byte", {24'h0, m_shift}, 32'h100);
                else check("sb_byte", {24'h0, m_shift}, {24'h0, exp_q.pop_front()});
            end else if (ACK && m_valid) begin
                m_valid = 1'b0;
            end
        end
    end

    // Cycle-by-cycle compare of every output against the model.
    always @(negedge CLK) begin
        if (RST_N && cyc > 0) begin
            check("outputs{data,valid,ferr,ovr,busy}",
                  {20'h0, DATA, VALID, FRAME_ERR, OVERRUN, BUSY},
                  {20'h0, m_data, m_valid, m_ferr, m_ovr, (m_active || m_wait)});
        end
    end

    // Event counters used by the directed literal checks.
    int ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0, rise_cyc = 0, start_cyc = 0;
    logic prev_valid = 1'b0;
    always @(negedge CLK) begin
        if (RST_N) begin
            if (FRAME_ERR) ferr_cnt++;
            if (OVERRUN) ovr_cnt++;
            if (BUSY) busy_cnt++;
            if (VALID && !prev_valid) rise_cyc = cyc;
            prev_valid = VALID;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Random consumer acknowledge, enabled only during the random phase.
    bit rand_ack_en = 0;
    always begin
        @(posedge CLK);
        #2;
        if (rand_ack_en) ACK = ($urandom_range(0, 3) == 0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input int n);
        UART_RX = 1'b1;
        repeat (n) tick();
    endtask

    task automatic ack_pulse();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
    endtask

    // Drives one frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit push);
        if (push) exp_q.push_back(b);
        start_cyc = cyc;
        UART_RX = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (CPB) tick();
        end
        UART_RX = stop_bit;
        repeat (CPB) tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        RST_N = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {20'h0, DATA, VALID, FRAME_ERR, OVERRUN, BUSY}, 32'h0);
        RST_N = 1'b1;
        idle(4);

        // Basic byte, latency and ACK.
        send_frame(8'hA5, 1'b1, 1);
        idle(20);
        check("latency_a5", rise_cyc - start_cyc, 155);
        check("data_a5", {24'h0, DATA}, 32'hA5);
        check("valid_a5", {31'h0, VALID}, 32'h1);
        ack_pulse();
        check("valid_after_ack", {31'h0, VALID}, 32'h0);
        idle(5);

        // Short low glitch on an idle line.
        busy_cnt = 0; ferr_cnt = 0;
        UART_RX = 1'b0;
        repeat (5) tick();
        idle(30);
        check("glitch_busy_cycles", busy_cnt, 8);
        check("glitch_valid", {31'h0, VALID}, 32'h0);
        check("glitch_ferr", ferr_cnt, 0);

        // Bad stop bit followed by a long break.
        ferr_cnt = 0;
        send_frame(8'h3C, 1'b0, 0);
        UART_RX = 1'b0;
        repeat (40 * CPB) tick();
        check("break_busy_held", {31'h0, BUSY}, 32'h1);
        idle(10);
        check("break_ferr_count", ferr_cnt, 1);
        check("break_valid", {31'h0, VALID}, 32'h0);
        check("break_busy_released", {31'h0, BUSY}, 32'h0);

        // Back-to-back bytes without ACK.
        ovr_cnt = 0;
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        idle(20);
        check("ovr_data", {24'h0, DATA}, 32'h22);
        check("ovr_valid", {31'h0, VALID}, 32'h1);
        check("ovr_count", ovr_cnt, 1);
        ack_pulse();
        idle(5);

        // ACK lands exactly on the second completion edge.
        ovr_cnt = 0;
        send_frame(8'h33, 1'b1, 1);
        fork
            send_frame(8'h44, 1'b1, 1);
            begin
                repeat (154) tick();
                ACK = 1'b1;
                tick();
                ACK = 1'b0;
            end
        join
        idle(20);
        check("coinc_data", {24'h0, DATA}, 32'h44);
        check("coinc_valid", {31'h0, VALID}, 32'h1);
        check("coinc_ovr_count", ovr_cnt, 0);

        // Reset during data bit 4 of 0xFF, with 0x44 still held.
        UART_RX = 1'b0;
        repeat (CPB) tick();
        UART_RX = 1'b1;
        repeat (4 * CPB + CPB / 2) tick();
        RST_N = 1'b0;
        #1;
        check("midframe_reset_outputs", {20'h0, DATA, VALID, FRAME_ERR, OVERRUN, BUSY}, 32'h0);
        repeat (3) tick();
        RST_N = 1'b1;
        idle(5);
        send_frame(8'h5A, 1'b1, 1);
        idle(20);
        check("post_reset_data", {24'h0, DATA}, 32'h5A);
        check("post_reset_valid", {31'h0, VALID}, 32'h1);
        ack_pulse();

        // Random phase: random bytes, gaps, glitches, bad stops and ACKs.
        rand_ack_en = 1;
        for (int n = 0; n < 25; n++) begin
            logic [7:0] b;
            int gap;
            b   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 30);
            if ($urandom_range(0, 3) == 0) begin
                UART_RX = 1'b0;
                repeat ($urandom_range(1, 5)) tick();
                idle(20);
            end
            if ($urandom_range(0, 5) == 0) begin
                send_frame(b, 1'b0, 0);
                UART_RX = 1'b0;
                repeat ($urandom_range(0, 3 * CPB)) tick();
                idle(4 + gap);
            end else begin
                send_frame(b, 1'b1, 1);
                idle(gap);
            end
        end
        rand_ack_en = 0;
        tick();
        ACK = 1'b0;
        idle(40);
        check("sb_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
